// File: rtl/dds_pkg.sv
// Shared types and widths for the DDS configurator / phase generator pair.
// Latency: n/a (package only).
// Backpressure: n/a.
package dds_pkg;

  localparam int FTW_W       = 24;
  localparam int AMP_W       = 8;
  localparam int POW_W       = 16;
  localparam int ACC_W_DEF   = 32;
  localparam int AXIL_ADDR_W = 8;
  localparam int AXIL_DATA_W = 32;

  typedef logic [FTW_W-1:0]     t_ftw;
  typedef logic [AMP_W-1:0]     t_amp;
  typedef logic [ACC_W_DEF-1:0] t_acc;

  // Channel index width: enough bits for n slots, never narrower than 1.
  function automatic int chn_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// One DDS lane: phase-continuous accumulator plus offset phase output.
// Latency: phase reflects the accumulator one cycle after it updates.
// Backpressure: none; step/clear are applied every cycle they are asserted.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int PH_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  t_ftw             ftw,
  input  logic             clear,
  input  logic             step,
  input  logic [POW_W-1:0] pow,
  output logic [PH_W-1:0]  phase
);

  logic [ACC_W-1:0] acc;

  // Accumulator: clear wins over step, otherwise add the zero-extended FTW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + ACC_W'(ftw);
    end
  end

  // Output phase: top PH_W accumulator bits plus the top PH_W offset bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else begin
      phase <= acc[ACC_W-1 -: PH_W] + pow[POW_W-1 -: PH_W];
    end
  end

endmodule

// File: rtl/dds_hop_phase_gen.sv
// Frequency-hopping phase generator: shadow FTW bank, commit on sync edge, slot sequencer.
// Latency: outputs registered one cycle after the accumulator/slot update.
// Backpressure: stream always ready after reset; out-of-range beats are dropped and flagged.
module dds_hop_phase_gen
  import dds_pkg::*;
#(
  parameter int DDS_NUM      = 4,
  parameter int CONFIG_WIDTH = 4,
  parameter int ACC_W        = 32,
  parameter int PH_W         = 16,
  parameter int G_DWELL      = 1000,
  parameter int CHN_W        = chn_w(CONFIG_WIDTH)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [DDS_NUM*FTW_W-1:0]              i_stm_data,
  input  logic [CHN_W-1:0]                      i_stm_chn,
  input  logic                                  i_stm_vld,
  input  logic                                  i_stm_syn,
  output logic                                  o_stm_rdy,
  input  logic                                  i_ena,
  input  logic [DDS_NUM*CONFIG_WIDTH*AMP_W-1:0] i_amp_cfg,
  input  logic [POW_W-1:0]                      i_pow_cfg,
  output logic [DDS_NUM*PH_W-1:0]               o_phase,
  output logic [DDS_NUM*AMP_W-1:0]              o_amp,
  output logic [CHN_W-1:0]                      o_slot,
  output logic                                  o_vld,
  output logic                                  o_hop,
  output logic                                  o_chn_err
);

  localparam int DW_W = $clog2(G_DWELL);

  t_ftw                                  shadow     [DDS_NUM][CONFIG_WIDTH];
  t_ftw                                  active_ftw [DDS_NUM][CONFIG_WIDTH];
  logic [DDS_NUM*CONFIG_WIDTH*AMP_W-1:0] active_amp;
  logic [POW_W-1:0]                      active_pow;
  logic                                  syn_d;
  logic                                  en_q;
  logic                                  hop_r;
  logic [CHN_W-1:0]                      slot;
  logic [CHN_W-1:0]                      slot_next;
  logic [DW_W-1:0]                       dwell;
  logic [CONFIG_WIDTH-1:0]               chn_hit;
  logic                                  beat_ok;
  logic                                  beat_bad;
  logic                                  commit;
  logic                                  wrap;
  t_ftw                                  lane_ftw   [DDS_NUM];
  t_amp                                  lane_amp   [DDS_NUM];

  // Decode the beat channel against the valid slot range.
  always_comb begin
    chn_hit = '0;
    for (int s = 0; s < CONFIG_WIDTH; s++) begin
      chn_hit[s] = (i_stm_chn == CHN_W'(s));
    end
  end

  assign beat_ok   = i_stm_vld & o_stm_rdy & (|chn_hit);
  assign beat_bad  = i_stm_vld & o_stm_rdy & ~(|chn_hit);
  assign commit    = i_stm_syn & ~syn_d;
  assign wrap      = (dwell == DW_W'(G_DWELL - 1));
  assign slot_next = (slot == CHN_W'(CONFIG_WIDTH - 1)) ? '0 : slot + 1'b1;

  // Select the active slot's FTW and amplitude for every lane.
  always_comb begin
    for (int d = 0; d < DDS_NUM; d++) begin
      lane_ftw[d] = '0;
      lane_amp[d] = '0;
      for (int s = 0; s < CONFIG_WIDTH; s++) begin
        if (slot == CHN_W'(s)) begin
          lane_ftw[d] = active_ftw[d][s];
          lane_amp[d] = active_amp[(d*CONFIG_WIDTH+s)*AMP_W +: AMP_W];
        end
      end
    end
  end

  // Stream side: ready, sync edge detect, shadow capture, sticky channel error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stm_rdy <= 1'b0;
      syn_d     <= 1'b0;
      o_chn_err <= 1'b0;
      for (int d = 0; d < DDS_NUM; d++)
        for (int s = 0; s < CONFIG_WIDTH; s++)
          shadow[d][s] <= '0;
    end else begin
      o_stm_rdy <= 1'b1;
      syn_d     <= i_stm_syn;
      if (beat_bad) o_chn_err <= 1'b1;
      if (beat_ok) begin
        for (int d = 0; d < DDS_NUM; d++)
          for (int s = 0; s < CONFIG_WIDTH; s++)
            if (chn_hit[s]) shadow[d][s] <= i_stm_data[d*FTW_W +: FTW_W];
      end
    end
  end

  // Commit: copy the pre-edge shadow plus amplitude/offset config into the active bank.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      active_amp <= '0;
      active_pow <= '0;
      for (int d = 0; d < DDS_NUM; d++)
        for (int s = 0; s < CONFIG_WIDTH; s++)
          active_ftw[d][s] <= '0;
    end else if (commit) begin
      active_amp <= i_amp_cfg;
      active_pow <= i_pow_cfg;
      active_ftw <= shadow;
    end
  end

  // Sequencer: commit restarts slot/dwell, otherwise dwell counts and hops while enabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      en_q  <= 1'b0;
      slot  <= '0;
      dwell <= '0;
      hop_r <= 1'b0;
    end else begin
      en_q  <= i_ena;
      hop_r <= 1'b0;
      if (commit) begin
        slot  <= '0;
        dwell <= '0;
        hop_r <= 1'b1;
      end else if (en_q) begin
        if (wrap) begin
          dwell <= '0;
          slot  <= slot_next;
          hop_r <= 1'b1;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end
    end
  end

  // Output stage aligned with the lane phase registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_slot <= '0;
      o_vld  <= 1'b0;
      o_hop  <= 1'b0;
      o_amp  <= '0;
    end else begin
      o_slot <= slot;
      o_vld  <= en_q;
      o_hop  <= hop_r;
      for (int d = 0; d < DDS_NUM; d++) o_amp[d*AMP_W +: AMP_W] <= lane_amp[d];
    end
  end

  for (genvar d = 0; d < DDS_NUM; d++) begin : g_lane
    dds_phase_acc #(
      .ACC_W (ACC_W),
      .PH_W  (PH_W)
    ) u_acc (
      .clk   (i_clk),
      .rst   (i_rst),
      .ftw   (lane_ftw[d]),
      .clear (commit),
      .step  (en_q),
      .pow   (active_pow),
      .phase (o_phase[d*PH_W +: PH_W])
    );
  end

endmodule

// File: tb/tb_dds_hop_phase_gen.sv
// Directed bench for dds_hop_phase_gen: hopping, commit precedence, enable hold, errors, reset.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: stream is never stalled by the bench; rdy is checked directly.
module tb_dds_hop_phase_gen;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [95:0]  i_stm_data;
  logic [2:0]   i_stm_chn;
  logic         i_stm_vld;
  logic         i_stm_syn;
  logic         o_stm_rdy;
  logic         i_ena;
  logic [127:0] i_amp_cfg;
  logic [15:0]  i_pow_cfg;
  logic [63:0]  o_phase;
  logic [31:0]  o_amp;
  logic [2:0]   o_slot;
  logic         o_vld;
  logic         o_hop;
  logic         o_chn_err;

  int total = 0;
  int bad   = 0;

  dds_hop_phase_gen #(
    .DDS_NUM(4), .CONFIG_WIDTH(4), .ACC_W(32), .PH_W(16), .G_DWELL(4), .CHN_W(3)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_stm_data(i_stm_data), .i_stm_chn(i_stm_chn),
    .i_stm_vld(i_stm_vld), .i_stm_syn(i_stm_syn), .o_stm_rdy(o_stm_rdy), .i_ena(i_ena),
    .i_amp_cfg(i_amp_cfg), .i_pow_cfg(i_pow_cfg), .o_phase(o_phase), .o_amp(o_amp),
    .o_slot(o_slot), .o_vld(o_vld), .o_hop(o_hop), .o_chn_err(o_chn_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] chn, input logic [23:0] d0, input logic [23:0] d1,
                      input logic [23:0] d2, input logic [23:0] d3);
    i_stm_data = {d3, d2, d1, d0};
    i_stm_chn  = chn;
    i_stm_vld  = 1'b1;
    tick();
    i_stm_vld  = 1'b0;
  endtask

  function automatic logic [127:0] amp_pat(input logic [7:0] base);
    logic [127:0] v;
    v = '0;
    for (int d = 0; d < 4; d++)
      for (int s = 0; s < 4; s++)
        v[(d*4+s)*8 +: 8] = base + 8'(d*16 + s);
    return v;
  endfunction

  initial begin
    logic [31:0] exp_ph;
    int          sl;

    i_rst = 1'b1; i_stm_data = '0; i_stm_chn = '0; i_stm_vld = 1'b0; i_stm_syn = 1'b0;
    i_ena = 1'b0; i_amp_cfg = '0; i_pow_cfg = '0;

    // Reset held, then released
    repeat (3) tick();
    check("rst_phase", 32'(o_phase[31:0]), 32'h0);
    check("rst_phase_hi", 32'(o_phase[63:32]), 32'h0);
    check("rst_amp", o_amp, 32'h0);
    check("rst_flags", {27'd0, o_slot, o_vld, o_hop}, 32'h0);
    check("rst_rdy", 32'(o_stm_rdy), 32'h0);
    check("rst_err", 32'(o_chn_err), 32'h0);
    i_rst = 1'b0;
    #1;
    check("rdy_before_edge", 32'(o_stm_rdy), 32'h0);
    tick();
    check("rdy_after_edge", 32'(o_stm_rdy), 32'h1);
    check("vld_idle", 32'(o_vld), 32'h0);

    // Hopping: lane1 steps 0x10*(s+1) per cycle in phase, lane2 steps (s+1)
    i_ena = 1'b1;
    beat(3'd0, 24'h000100, 24'h100000, 24'h010000, 24'h0);
    beat(3'd1, 24'h000200, 24'h200000, 24'h020000, 24'h0);
    beat(3'd2, 24'h000300, 24'h300000, 24'h030000, 24'h0);
    beat(3'd3, 24'h000400, 24'h400000, 24'h040000, 24'h0);
    i_amp_cfg = amp_pat(8'h10);
    i_pow_cfg = 16'h0;
    i_stm_syn = 1'b1;
    tick();
    tick();
    i_stm_syn = 1'b0;
    exp_ph = 0;
    for (int n = 0; n <= 12; n++) begin
      sl = (n / 4) % 4;
      check($sformatf("hop_slot_%0d", n), 32'(o_slot), 32'(sl));
      check($sformatf("hop_pulse_%0d", n), 32'(o_hop), 32'((n % 4) == 0));
      check($sformatf("hop_ph1_%0d", n), 32'(o_phase[31:16]), exp_ph);
      check($sformatf("hop_ph2_%0d", n), 32'(o_phase[47:32]), exp_ph / 16);
      check($sformatf("hop_amp1_%0d", n), 32'(o_amp[15:8]), 32'h20 + 32'(sl));
      check($sformatf("hop_vld_%0d", n), 32'(o_vld), 32'h1);
      exp_ph = exp_ph + 32'((sl + 1) * 16);
      tick();
    end

    // Sync edge on the dwell-wrap cycle, with a beat in the same cycle
    tick();
    i_stm_syn = 1'b1;
    beat(3'd0, 24'h000900, 24'h800000, 24'h080000, 24'h0);
    tick();
    i_stm_syn = 1'b0;
    for (int m = 0; m <= 15; m++) begin
      exp_ph = (m <= 2) ? 32'(m * 16) : (m <= 13) ? 32'h30 : (m == 14) ? 32'h40 : 32'h60;
      check($sformatf("ena_ph1_%0d", m), 32'(o_phase[31:16]), exp_ph);
      check($sformatf("ena_vld_%0d", m), 32'(o_vld), 32'(!(m >= 3 && m <= 12)));
      check($sformatf("ena_slot_%0d", m), 32'(o_slot), 32'(m >= 14));
      check($sformatf("ena_hop_%0d", m), 32'(o_hop), 32'(m == 0 || m == 14));
      if (m == 1) i_ena = 1'b0;
      if (m == 11) i_ena = 1'b1;
      tick();
    end
    i_stm_syn = 1'b1;
    tick();
    i_stm_syn = 1'b0;
    tick();
    check("newbank_ph1_0", 32'(o_phase[31:16]), 32'h0);
    tick();
    check("newbank_ph1_1", 32'(o_phase[31:16]), 32'h80);
    check("newbank_ph2_1", 32'(o_phase[47:32]), 32'h8);

    // Zero bank with phase offset, out-of-range channel, amplitude capture
    beat(3'd0, 24'h0, 24'h0, 24'h0, 24'h0);
    beat(3'd1, 24'h0, 24'h0, 24'h0, 24'h0);
    beat(3'd2, 24'h0, 24'h0, 24'h0, 24'h0);
    beat(3'd3, 24'h0, 24'h0, 24'h0, 24'h0);
    check("err_before", 32'(o_chn_err), 32'h0);
    beat(3'd5, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    check("err_set", 32'(o_chn_err), 32'h1);
    i_pow_cfg = 16'h4000;
    i_amp_cfg = amp_pat(8'h80);
    i_stm_syn = 1'b1;
    tick();
    i_stm_syn = 1'b0;
    tick();
    for (int m = 0; m <= 7; m++) begin
      sl = (m / 4) % 4;
      for (int d = 0; d < 4; d++) begin
        check($sformatf("pow_ph_%0d_%0d", m, d), 32'(o_phase[d*16 +: 16]), 32'h4000);
        check($sformatf("pow_amp_%0d_%0d", m, d), 32'(o_amp[d*8 +: 8]), 32'(8'h80 + 8'(d*16 + sl)));
      end
      if (m == 4) i_amp_cfg = amp_pat(8'hC0);
      tick();
    end
    i_stm_syn = 1'b1;
    tick();
    i_stm_syn = 1'b0;
    tick();
    tick();
    check("err_sticky", 32'(o_chn_err), 32'h1);
    check("pow_ph_recommit", 32'(o_phase[15:0]), 32'h4000);

    // Asynchronous reset mid-run, no clock edge needed
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_phase", 32'(o_phase[31:0]), 32'h0);
    check("arst_phase_hi", 32'(o_phase[63:32]), 32'h0);
    check("arst_flags", {26'd0, o_slot, o_vld, o_hop, o_chn_err}, 32'h0);
    check("arst_rdy", 32'(o_stm_rdy), 32'h0);
    tick();
    tick();
    i_rst = 1'b0;
    i_pow_cfg = 16'h1234;

    // Commit with the shadow bank never written since reset
    tick();
    i_stm_syn = 1'b1;
    tick();
    i_stm_syn = 1'b0;
    tick();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("empty_ph_%0d", d), 32'(o_phase[d*16 +: 16]), 32'h1234);
      check($sformatf("empty_amp_%0d", d), 32'(o_amp[d*8 +: 8]), 32'(8'hC0 + 8'(d*16)));
    end
    check("empty_err", 32'(o_chn_err), 32'h0);
    check("empty_vld", 32'(o_vld), 32'h1);
    tick();
    check("empty_ph_hold", 32'(o_phase[31:16]), 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
